// File: rtl/expr_eval_pkg.sv
`default_nettype none
// ============================================================================
// Package     : expr_pkg
// Description : Shared constants for the expression evaluator: one-hot state
//               encoding, ASCII character codes and the operator encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package expr_pkg;

  // One-hot state encoding
  localparam logic [3:0] c_st_start = 4'b0001;
  localparam logic [3:0] c_st_num   = 4'b0010;
  localparam logic [3:0] c_st_opnd  = 4'b0100;
  localparam logic [3:0] c_st_err   = 4'b1000;

  typedef enum logic [3:0] {
    ST_START = c_st_start,
    ST_NUM   = c_st_num,
    ST_OPND  = c_st_opnd,
    ST_ERR   = c_st_err
  } state_t;

  // ASCII codes recognised by the parser
  localparam logic [7:0] c_ascii_0    = 8'h30;
  localparam logic [7:0] c_ascii_9    = 8'h39;
  localparam logic [7:0] c_ascii_plus = 8'h2B;
  localparam logic [7:0] c_ascii_star = 8'h2A;
  localparam logic [7:0] c_ascii_eq   = 8'h3D;

  // Operator encoding
  localparam logic c_op_add = 1'b0;
  localparam logic c_op_mul = 1'b1;

endpackage
`default_nettype wire

// File: rtl/expr_eval_if.sv
`default_nettype none
// ============================================================================
// Interface   : expr_eval_if
// Description : Character stream in, evaluation status/result out.
// Revision    : 1.0 - initial release
// ============================================================================
interface expr_eval_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [7:0]       in;
  logic [WIDTH-1:0] result;
  logic             ok;
  logic             done;
  logic             err;

  modport master (output in_valid, output in,
                  input  result, input ok, input done, input err);
  modport slave  (input  in_valid, input in,
                  output result, output ok, output done, output err);
endinterface
`default_nettype wire

// File: rtl/expr_eval_char_class.sv
`default_nettype none
// ============================================================================
// Module      : expr_char_class
// Description : Combinational classifier for one ASCII input character.
// Revision    : 1.0 - initial release
// ============================================================================
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_op,
  output logic       op,
  output logic       is_eq,
  output logic [3:0] digit
);

  assign is_digit = (in >= c_ascii_0) && (in <= c_ascii_9);
  assign is_op    = (in == c_ascii_plus) || (in == c_ascii_star);
  assign op       = (in == c_ascii_star) ? c_op_mul : c_op_add;
  assign is_eq    = (in == c_ascii_eq);
  // '0' is 8'h30, so for digits the low nibble already equals in - 8'h30
  assign digit    = in[3:0];

endmodule
`default_nettype wire

// File: rtl/expr_eval.sv
`default_nettype none
// ============================================================================
// Module      : expr_eval
// Description : Streaming evaluator for single-digit expressions with '+' and
//               '*' (multiply binds tighter), terminated by '='. Keeps a
//               running sum of completed product terms plus the current term.
// Revision    : 1.0 - initial release
// ============================================================================
module expr_eval
  import expr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       clr,
  expr_eval_if.slave bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] r_result;
  logic             r_pending_op;
  logic             r_ok;
  logic             r_done;
  logic             r_err;

  logic             w_is_digit;
  logic             w_is_op;
  logic             w_op;
  logic             w_is_eq;
  logic [3:0]       w_digit;
  logic [WIDTH-1:0] w_digit_ext;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_sum_term;
  logic [WIDTH-1:0] w_mul_result;
  logic [WIDTH-1:0] w_add_result;

  expr_char_class u_char_class (
    .in       (bus.in),
    .is_digit (w_is_digit),
    .is_op    (w_is_op),
    .op       (w_op),
    .is_eq    (w_is_eq),
    .digit    (w_digit)
  );

  // Operand datapath; the multiplier's second operand is only 4 bits wide
  assign w_digit_ext  = {{(WIDTH-4){1'b0}}, w_digit};
  assign w_prod       = r_term * w_digit_ext;
  assign w_sum_term   = r_sum + r_term;
  assign w_mul_result = r_sum + w_prod;
  assign w_add_result = w_sum_term + w_digit_ext;

  assign bus.result = r_result;
  assign bus.ok     = r_ok;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

  // Parser FSM with accumulator update and registered status outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= ST_START;
      r_sum        <= '0;
      r_term       <= '0;
      r_result     <= '0;
      r_pending_op <= c_op_add;
      r_ok         <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // done is a single-cycle pulse, so it drops whenever '=' is not accepted
      r_done <= 1'b0;
      if (bus.in_valid) begin
        unique case (r_state)
          ST_START: begin
            if (w_is_digit) begin
              r_sum    <= '0;
              r_term   <= w_digit_ext;
              r_result <= w_digit_ext;
              r_state  <= ST_NUM;
              r_ok     <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_ok    <= 1'b0;
              r_err   <= 1'b1;
            end
          end
          ST_NUM: begin
            if (w_is_op) begin
              r_pending_op <= w_op;
              r_state      <= ST_OPND;
              r_ok         <= 1'b0;
            end else if (w_is_eq) begin
              r_state <= ST_START;
              r_ok    <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_ok    <= 1'b0;
              r_err   <= 1'b1;
            end
          end
          ST_OPND: begin
            if (w_is_digit) begin
              if (r_pending_op == c_op_mul) begin
                r_term   <= w_prod;
                r_result <= w_mul_result;
              end else begin
                r_sum    <= w_sum_term;
                r_term   <= w_digit_ext;
                r_result <= w_add_result;
              end
              r_state <= ST_NUM;
              r_ok    <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_ok    <= 1'b0;
              r_err   <= 1'b1;
            end
          end
          ST_ERR: begin
            r_state <= ST_ERR;
            r_ok    <= 1'b0;
            r_err   <= 1'b1;
          end
          default: begin
            r_state <= ST_ERR;
            r_ok    <= 1'b0;
            r_err   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/expr_eval.md
EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the accumulator and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the character on in is consumed on this clock edge.
REQ-005 The block SHALL have port in, input, 8 bits: ASCII character, one of '0'-'9', '+', '*', '=', or any other value.
REQ-006 The block SHALL have port result, output, WIDTH bits: value of the expression accepted so far.
REQ-007 The block SHALL have port ok, output, 1 bit: the accepted prefix is a complete, valid expression.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when '=' terminates a valid expression.
REQ-009 The block SHALL have port err, output, 1 bit: sticky syntax error.

Function
REQ-010 Grammar SHALL be: single digit, then zero or more (op digit) pairs, then '='; op SHALL be '+' or '*'.
REQ-011 The FSM SHALL have four states:
- START: expect a digit.
- NUM: digit seen, expect an op or '='.
- OPND: op seen, expect a digit.
- ERR: error.
REQ-012 The block SHALL consume a character only on clock edges where in_valid=1; with in_valid=0, all state and outputs SHALL hold.
REQ-013 START SHALL handle characters as follows:
- digit d: term=d, sum=0, then NUM.
- any other character: ERR.
REQ-014 NUM SHALL handle characters as follows:
- '+' or '*': latch pending_op, then OPND.
- '=': then START.
- any other character: ERR.
REQ-015 OPND SHALL handle characters as follows:
- digit d with pending_op='*': term=term*d.
- digit d with pending_op='+': sum=sum+term, term=d.
- either case: then NUM.
- any other character: ERR.
REQ-016 ERR SHALL be absorbing until clr.
REQ-017 '*' SHALL bind tighter than '+'; evaluation SHALL be left to right within each precedence level.
REQ-018 All arithmetic SHALL be unsigned modulo 2^WIDTH; overflow SHALL wrap silently and SHALL NOT set err.
REQ-019 result SHALL be registered and SHALL equal next_sum+next_term, updated on the same edge as the digit that is consumed (latency 1 clock from in_valid).
REQ-020 result SHALL hold its value while in OPND, across '=', and through ERR.
REQ-021 ok SHALL be 1 exactly when the state is NUM.
REQ-022 err SHALL be 1 exactly when the state is ERR.
REQ-023 done SHALL be registered and SHALL be 1 for exactly the cycle after '=' is accepted in NUM.
REQ-024 After '=' the next expression SHALL start fresh from START; its first digit SHALL overwrite result.
REQ-025 An '=' received in START or OPND SHALL go to ERR without a done pulse.
REQ-026 Digit value SHALL be in minus 8'h30; '0' SHALL be a legal operand.

Reset
REQ-027 clr=1 SHALL asynchronously force: state=START, sum=0, term=0, pending_op='+', result=0, ok=0, done=0, err=0.
REQ-028 clr SHALL take priority over a simultaneous in_valid; the character on that edge SHALL be discarded.
REQ-029 clr asserted mid-expression or in ERR SHALL abandon all partial results.

Structure
REQ-030 A shared package expr_pkg SHALL hold:
- state encoding constants (one-hot, 4 bits);
- ASCII constants for '0', '9', '+', '*', '=';
- the op encoding (1 bit: 0='+', 1='*').
REQ-031 The block SHALL contain one sub-module, expr_char_class: combinational, mapping in[7:0] to {is_digit, is_op, op, is_eq, digit[3:0]}.
REQ-032 The multiply SHALL be WIDTH x 4 bits; no divider and no other arithmetic SHALL be present.

Verification
REQ-033 Precedence: "2+3*4=" streamed with in_valid=1 -> result 2,2,5,5,14; ok=1 after each digit; done=1 for one cycle after '='; final result 14.
REQ-034 Wrap: WIDTH=8, "9*9*9*9" -> result 9,81,729 mod 256=217,1953 mod 256=161; err=0.
REQ-035 Errors: "1++2" -> err=1 from the second '+' onward, ok=0, result held at 1; a following "3=" leaves err=1 with no done pulse.
REQ-036 Leading '=' and an illegal char: "=" from START -> err=1, done=0; after clr, "7a" -> err=1 after 'a', result=7.
REQ-037 Stalls and back-to-back: "4*5" with in_valid=0 gaps of 3 cycles between characters -> outputs stable during gaps, result 20; then "=" followed directly by "1+1=" -> done pulses twice, final result 2.
REQ-038 Reset mid-operation: clr asserted between clock edges after "8+" -> result, ok, err and done=0 immediately; clr held high with in_valid=1 and in='5' -> nothing consumed.
